// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage FSM states and the EX/MEM serial bundle layout.
package mips_pipe_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_e;

    localparam int SERIAL_W         = 65;
    localparam int SER_MEMWRITE_BIT = 64;
    localparam int SER_ADDR_MSB     = 63;
    localparam int SER_ADDR_LSB     = 32;
    localparam int SER_DATA_MSB     = 31;
    localparam int REG_ADDR_W       = 5;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over a req/ack port, stalls while an access is outstanding,
// drives MEM/WB. Latency 1 for ALU ops, >=2 for memory ops; a silent memory aborts after TIMEOUT_CYCLES.
module mem_access_stage
    import mips_pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic [SERIAL_W-1:0]   EDIT_SERIAL,
    input  logic [31:0]           ALUOutM,
    input  logic [REG_ADDR_W-1:0] wb_addrM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  ENABLE_MEM,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [31:0]           dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [31:0]           dmem_rdata,
    output logic                  STALL_MEM,
    output logic [31:0]           ReadDataW,
    output logic [31:0]           ALUOutW,
    output logic [REG_ADDR_W-1:0] wb_addrW,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic                  ENABLE_WB,
    output logic                  MISALIGN_ERR,
    output logic                  BUS_ERR
);

    mem_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;

    logic                  r_req;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;

    logic [31:0]           r_read_data;
    logic [31:0]           r_alu_out;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic                  r_enable_wb;
    logic                  r_misalign_err;
    logic                  r_bus_err;

    // Instruction context captured on entering REQ; retire uses these, not the live inputs.
    logic [31:0]           r_hold_alu;
    logic [REG_ADDR_W-1:0] r_hold_wb_addr;
    logic                  r_hold_reg_write;
    logic                  r_hold_mem_to_reg;

    logic                  w_mem_write;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic                  w_need;
    logic                  w_aligned;
    logic                  w_timeout;

    assign w_mem_write = EDIT_SERIAL[SER_MEMWRITE_BIT];
    assign w_addr      = EDIT_SERIAL[SER_ADDR_MSB:SER_ADDR_LSB];
    assign w_wdata     = EDIT_SERIAL[SER_DATA_MSB:0];
    assign w_need      = ENABLE_MEM & (w_mem_write | MemtoRegM);
    assign w_aligned   = is_word_aligned(w_addr);
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // The abort cycle releases the stall so upstream advances together with the bubble.
    assign STALL_MEM = ((r_state == IDLE) & w_need & w_aligned)
                     | ((r_state == REQ) & ~dmem_ack & ~w_timeout);

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_state           <= IDLE;
            r_cnt             <= '0;
            r_req             <= 1'b0;
            r_we              <= 1'b0;
            r_addr            <= '0;
            r_wdata           <= '0;
            r_read_data       <= '0;
            r_alu_out         <= '0;
            r_wb_addr         <= '0;
            r_reg_write       <= 1'b0;
            r_mem_to_reg      <= 1'b0;
            r_enable_wb       <= 1'b0;
            r_misalign_err    <= 1'b0;
            r_bus_err         <= 1'b0;
            r_hold_alu        <= '0;
            r_hold_wb_addr    <= '0;
            r_hold_reg_write  <= 1'b0;
            r_hold_mem_to_reg <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!ENABLE_MEM) begin
                        r_enable_wb <= 1'b0;
                        r_reg_write <= 1'b0;
                    end else if (!w_need) begin
                        r_alu_out    <= ALUOutM;
                        r_wb_addr    <= wb_addrM;
                        r_reg_write  <= RegWriteM;
                        r_mem_to_reg <= MemtoRegM;
                        r_enable_wb  <= 1'b1;
                    end else if (!w_aligned) begin
                        r_enable_wb    <= 1'b0;
                        r_reg_write    <= 1'b0;
                        r_misalign_err <= 1'b1;
                    end else begin
                        r_req             <= 1'b1;
                        r_we              <= w_mem_write;
                        r_addr            <= w_addr;
                        r_wdata           <= w_wdata;
                        r_cnt             <= '0;
                        r_enable_wb       <= 1'b0;
                        r_hold_alu        <= ALUOutM;
                        r_hold_wb_addr    <= wb_addrM;
                        r_hold_reg_write  <= RegWriteM;
                        // A store wins over MemtoReg, so WB must never select memory data for it.
                        r_hold_mem_to_reg <= MemtoRegM & ~w_mem_write;
                        r_state           <= REQ;
                    end
                end

                REQ: begin
                    if (dmem_ack) begin
                        r_alu_out    <= r_hold_alu;
                        r_wb_addr    <= r_hold_wb_addr;
                        r_reg_write  <= r_hold_reg_write;
                        r_mem_to_reg <= r_hold_mem_to_reg;
                        r_enable_wb  <= 1'b1;
                        if (!r_we) begin
                            r_read_data <= dmem_rdata;
                        end
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        r_req       <= 1'b0;
                        r_bus_err   <= 1'b1;
                        r_enable_wb <= 1'b0;
                        r_reg_write <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem_req     = r_req;
    assign dmem_we      = r_we;
    assign dmem_addr    = r_addr;
    assign dmem_wdata   = r_wdata;
    assign ReadDataW    = r_read_data;
    assign ALUOutW      = r_alu_out;
    assign wb_addrW     = r_wb_addr;
    assign RegWriteW    = r_reg_write;
    assign MemtoRegW    = r_mem_to_reg;
    assign ENABLE_WB    = r_enable_wb;
    assign MISALIGN_ERR = r_misalign_err;
    assign BUS_ERR      = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, load/store handshakes, misalign, timeout, reset.
module tb_mem_access_stage;

    logic        CLOCK;
    logic        RESET_N;
    logic [64:0] EDIT_SERIAL;
    logic [31:0] ALUOutM;
    logic [4:0]  wb_addrM;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic        ENABLE_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        STALL_MEM;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  wb_addrW;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic        ENABLE_WB;
    logic        MISALIGN_ERR;
    logic        BUS_ERR;

    int checks   = 0;
    int failures = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .EDIT_SERIAL  (EDIT_SERIAL),
        .ALUOutM      (ALUOutM),
        .wb_addrM     (wb_addrM),
        .RegWriteM    (RegWriteM),
        .MemtoRegM    (MemtoRegM),
        .ENABLE_MEM   (ENABLE_MEM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .STALL_MEM    (STALL_MEM),
        .ReadDataW    (ReadDataW),
        .ALUOutW      (ALUOutW),
        .wb_addrW     (wb_addrW),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .ENABLE_WB    (ENABLE_WB),
        .MISALIGN_ERR (MISALIGN_ERR),
        .BUS_ERR      (BUS_ERR)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic en, input logic mw, input logic mtr, input logic rw,
                             input logic [4:0] wb, input logic [31:0] addr, input logic [31:0] wdata);
        ENABLE_MEM  = en;
        EDIT_SERIAL = {mw, addr, wdata};
        ALUOutM     = addr;
        MemtoRegM   = mtr;
        RegWriteM   = rw;
        wb_addrM    = wb;
    endtask

    initial begin
        int hi;
        RESET_N    = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        tick();

        chk("rst_req",      dmem_req,     0);
        chk("rst_en_wb",    ENABLE_WB,    0);
        chk("rst_rdata",    ReadDataW,    0);
        chk("rst_alu",      ALUOutW,      0);
        chk("rst_misalign", MISALIGN_ERR, 0);
        chk("rst_bus",      BUS_ERR,      0);
        chk("rst_stall",    STALL_MEM,    0);
        RESET_N = 1'b1;

        // ALU op retires after one edge, never stalls
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h10, 32'h0);
        #1 chk("add_stall", STALL_MEM, 0);
        tick();
        chk("add_alu",    ALUOutW,   32'h10);
        chk("add_wbaddr", wb_addrW,  3);
        chk("add_regw",   RegWriteW, 1);
        chk("add_en_wb",  ENABLE_WB, 1);
        chk("add_req",    dmem_req,  0);

        // bubble clears valid and write-enable but holds the data fields
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        chk("bub_en_wb", ENABLE_WB, 0);
        chk("bub_regw",  RegWriteW, 0);
        chk("bub_alu",   ALUOutW,   32'h10);

        // LW 0x100, ack in the third REQ cycle
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0);
        #1 chk("lw_stall_idle", STALL_MEM, 1);
        tick();
        chk("lw_req_c1",   dmem_req,  1);
        chk("lw_we",       dmem_we,   0);
        chk("lw_addr",     dmem_addr, 32'h100);
        chk("lw_en_wb_c1", ENABLE_WB, 0);
        wb_addrM = 5'd9;
        #1 chk("lw_stall_c1", STALL_MEM, 1);
        tick();
        chk("lw_req_c2",   dmem_req, 1);
        #1 chk("lw_stall_c2", STALL_MEM, 1);
        tick();
        chk("lw_req_c3",   dmem_req, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1 chk("lw_stall_ack", STALL_MEM, 0);
        tick();
        dmem_ack = 1'b0;
        chk("lw_req_done", dmem_req,  0);
        chk("lw_rdata",    ReadDataW, 32'hDEADBEEF);
        chk("lw_mtr",      MemtoRegW, 1);
        chk("lw_en_wb",    ENABLE_WB, 1);
        chk("lw_wbaddr",   wb_addrW,  7);
        chk("lw_alu",      ALUOutW,   32'h100);
        chk("lw_regw",     RegWriteW, 1);

        // SW 0x204 with MemtoReg also set: store wins, immediate ack
        set_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h204, 32'h12345678);
        #1 chk("sw_stall_idle", STALL_MEM, 1);
        tick();
        chk("sw_req",   dmem_req,   1);
        chk("sw_we",    dmem_we,    1);
        chk("sw_addr",  dmem_addr,  32'h204);
        chk("sw_wdata", dmem_wdata, 32'h12345678);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1 chk("sw_stall_ack", STALL_MEM, 0);
        tick();
        dmem_ack = 1'b0;
        chk("sw_req_done", dmem_req,  0);
        chk("sw_regw",     RegWriteW, 0);
        chk("sw_rdata",    ReadDataW, 32'hDEADBEEF);
        chk("sw_mtr",      MemtoRegW, 0);
        chk("sw_en_wb",    ENABLE_WB, 1);

        // misaligned LW becomes a bubble without a request
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h102, 32'h0);
        #1 chk("mis_stall", STALL_MEM, 0);
        tick();
        chk("mis_req",   dmem_req,     0);
        chk("mis_flag",  MISALIGN_ERR, 1);
        chk("mis_en_wb", ENABLE_WB,    0);
        chk("mis_regw",  RegWriteW,    0);
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h55, 32'h0);
        tick();
        chk("mis_next_en_wb", ENABLE_WB,    1);
        chk("mis_next_alu",   ALUOutW,      32'h55);
        chk("mis_sticky",     MISALIGN_ERR, 1);

        // LW with no ack: 16 REQ cycles then abort
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h300, 32'h0);
        tick();
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (dmem_req) hi++;
            if (k == 0)  chk("to_stall_first", STALL_MEM, 1);
            if (k == 15) chk("to_stall_abort", STALL_MEM, 0);
            tick();
        end
        chk("to_req_cycles", hi,        16);
        chk("to_bus_err",    BUS_ERR,   1);
        chk("to_en_wb",      ENABLE_WB, 0);
        chk("to_regw",       RegWriteW, 0);
        chk("to_req",        dmem_req,  0);
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h77, 32'h0);
        tick();
        chk("to_idle_alu", ALUOutW, 32'h77);
        chk("to_idle_en",  ENABLE_WB, 1);

        // reset in the second REQ cycle, then a stray ack
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h400, 32'h0);
        tick();
        tick();
        chk("rr_req_c2", dmem_req, 1);
        RESET_N = 1'b0;
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        chk("rr_req",      dmem_req,     0);
        chk("rr_addr",     dmem_addr,    0);
        chk("rr_alu",      ALUOutW,      0);
        chk("rr_rdata",    ReadDataW,    0);
        chk("rr_en_wb",    ENABLE_WB,    0);
        chk("rr_wbaddr",   wb_addrW,     0);
        chk("rr_bus",      BUS_ERR,      0);
        chk("rr_misalign", MISALIGN_ERR, 0);
        RESET_N    = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        #1 chk("rr_stall_stray", STALL_MEM, 0);
        tick();
        dmem_ack = 1'b0;
        chk("rr_stray_rdata", ReadDataW, 0);
        chk("rr_stray_en_wb", ENABLE_WB, 0);
        chk("rr_stray_req",   dmem_req,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
